// File: rtl/iob_gpio_irq_pkg.sv
// rtl/iob_gpio_irq_pkg.sv - register offsets and bus helpers for the GPIO interrupt peripheral
package iob_gpio_irq_pkg;

  localparam int DBNC_W_DEFAULT = 16;
  localparam int MAX_DATA_W     = 64;

  localparam logic [31:0] REG_OUT      = 32'h00;
  localparam logic [31:0] REG_OUT_SET  = 32'h04;
  localparam logic [31:0] REG_OUT_CLR  = 32'h08;
  localparam logic [31:0] REG_OE       = 32'h0C;
  localparam logic [31:0] REG_IN       = 32'h10;
  localparam logic [31:0] REG_RISE_EN  = 32'h14;
  localparam logic [31:0] REG_FALL_EN  = 32'h18;
  localparam logic [31:0] REG_STATUS   = 32'h1C;
  localparam logic [31:0] REG_DEBOUNCE = 32'h20;

  // Expands byte enables into a bit mask; callers zero-extend narrower strobes.
  function automatic logic [MAX_DATA_W-1:0] wstrb_to_mask(input logic [MAX_DATA_W/8-1:0] wstrb);
    logic [MAX_DATA_W-1:0] mask;
    for (int i = 0; i < MAX_DATA_W/8; i++) begin
      mask[8*i +: 8] = {8{wstrb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/iob_gpio_irq_filter.sv
// rtl/iob_gpio_irq_filter.sv - input synchroniser with shared-prescaler debounce
module iob_gpio_irq_filter
  import iob_gpio_irq_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int DBNC_W = DBNC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] gpio_input,
  input  logic [DBNC_W-1:0] debounce,
  input  logic              debounce_wr,
  output logic [GPIO_W-1:0] filt
);

  logic [GPIO_W-1:0] sync_meta;
  logic [GPIO_W-1:0] sync;
  logic [GPIO_W-1:0] samp;
  logic [GPIO_W-1:0] stable;
  logic [DBNC_W-1:0] cnt;
  logic              bypass;
  logic              tick;

  assign bypass = (debounce == '0);
  assign tick   = !bypass && (cnt == debounce);
  // A pin is accepted only when two consecutive tick samples agree.
  assign stable = ~(sync ^ samp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
      samp      <= '0;
      filt      <= '0;
      cnt       <= '0;
    end else begin
      sync_meta <= gpio_input;
      sync      <= sync_meta;

      if (debounce_wr || bypass || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DBNC_W'(1);
      end

      if (bypass) begin
        filt <= sync;
      end else if (tick) begin
        samp <= sync;
        filt <= (sync & stable) | (filt & ~stable);
      end
    end
  end

endmodule

// File: rtl/iob_gpio_irq.sv
// rtl/iob_gpio_irq.sv - GPIO peripheral with set/clear outputs, debounced inputs and edge interrupts
module iob_gpio_irq
  import iob_gpio_irq_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DBNC_W = DBNC_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_rvalid,
  output logic                iob_ready,
  input  logic [GPIO_W-1:0]   gpio_input,
  output logic [GPIO_W-1:0]   gpio_output,
  output logic [GPIO_W-1:0]   gpio_output_enable,
  output logic                irq
);

  logic [31:0]             reg_off;
  logic                    wr_en;
  logic                    rd_en;
  logic [MAX_DATA_W/8-1:0] wstrb_ext;
  logic [MAX_DATA_W-1:0]   mask_ext;
  logic [GPIO_W-1:0]       pin_mask;
  logic [GPIO_W-1:0]       wd;
  logic [DBNC_W-1:0]       dbnc_mask;
  logic [DBNC_W-1:0]       dbnc_wd;
  logic                    dbnc_wr;
  logic [GPIO_W-1:0]       out_r;
  logic [GPIO_W-1:0]       oe_r;
  logic [GPIO_W-1:0]       rise_en;
  logic [GPIO_W-1:0]       fall_en;
  logic [GPIO_W-1:0]       status;
  logic [GPIO_W-1:0]       status_nxt;
  logic [GPIO_W-1:0]       filt;
  logic [GPIO_W-1:0]       filt_q;
  logic [GPIO_W-1:0]       event_hit;
  logic [DBNC_W-1:0]       debounce;
  logic [DATA_W-1:0]       rd_mux;
  logic                    unused_bits;

  assign reg_off = 32'({iob_addr[ADDR_W-1:2], 2'b00});
  assign wr_en   = iob_valid && (|iob_wstrb);
  assign rd_en   = iob_valid && !(|iob_wstrb);
  assign dbnc_wr = wr_en && (reg_off == REG_DEBOUNCE);

  always_comb begin
    wstrb_ext = '0;
    wstrb_ext[DATA_W/8-1:0] = iob_wstrb;
  end

  assign mask_ext    = wstrb_to_mask(wstrb_ext);
  assign pin_mask    = mask_ext[GPIO_W-1:0];
  assign wd          = iob_wdata[GPIO_W-1:0] & pin_mask;
  assign dbnc_mask   = mask_ext[DBNC_W-1:0];
  assign dbnc_wd     = iob_wdata[DBNC_W-1:0] & dbnc_mask;
  assign unused_bits = ^{iob_addr[1:0], mask_ext, iob_wdata};

  iob_gpio_irq_filter #(
    .GPIO_W (GPIO_W),
    .DBNC_W (DBNC_W)
  ) u_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .gpio_input  (gpio_input),
    .debounce    (debounce),
    .debounce_wr (dbnc_wr),
    .filt        (filt)
  );

  assign event_hit = (filt & ~filt_q & rise_en) | (~filt & filt_q & fall_en);

  // A new event on the same cycle as its W1C must survive the clear.
  always_comb begin
    status_nxt = status;
    if (wr_en && (reg_off == REG_STATUS)) begin
      status_nxt = status_nxt & ~wd;
    end
    status_nxt = status_nxt | event_hit;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_off)
      REG_OUT:      rd_mux[GPIO_W-1:0] = out_r;
      REG_OE:       rd_mux[GPIO_W-1:0] = oe_r;
      REG_IN:       rd_mux[GPIO_W-1:0] = filt;
      REG_RISE_EN:  rd_mux[GPIO_W-1:0] = rise_en;
      REG_FALL_EN:  rd_mux[GPIO_W-1:0] = fall_en;
      REG_STATUS:   rd_mux[GPIO_W-1:0] = status;
      REG_DEBOUNCE: rd_mux[DBNC_W-1:0] = debounce;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iob_ready  <= 1'b0;
      iob_rvalid <= 1'b0;
      iob_rdata  <= '0;
      out_r      <= '0;
      oe_r       <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      status     <= '0;
      debounce   <= '0;
      filt_q     <= '0;
      irq        <= 1'b0;
    end else begin
      iob_ready  <= iob_valid;
      iob_rvalid <= rd_en;
      if (rd_en) begin
        iob_rdata <= rd_mux;
      end
      filt_q <= filt;
      status <= status_nxt;
      irq    <= |status_nxt;
      if (wr_en) begin
        case (reg_off)
          REG_OUT:      out_r    <= (out_r & ~pin_mask) | wd;
          REG_OUT_SET:  out_r    <= out_r | wd;
          REG_OUT_CLR:  out_r    <= out_r & ~wd;
          REG_OE:       oe_r     <= (oe_r & ~pin_mask) | wd;
          REG_RISE_EN:  rise_en  <= (rise_en & ~pin_mask) | wd;
          REG_FALL_EN:  fall_en  <= (fall_en & ~pin_mask) | wd;
          REG_DEBOUNCE: debounce <= (debounce & ~dbnc_mask) | dbnc_wd;
          default:      ;
        endcase
      end
    end
  end

  assign gpio_output        = out_r;
  assign gpio_output_enable = oe_r;

endmodule

// File: tb/tb_iob_gpio_irq.sv
// tb/tb_iob_gpio_irq.sv - directed self-checking bench for iob_gpio_irq
module tb_iob_gpio_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iob_valid = 1'b0;
  logic [5:0]  iob_addr = '0;
  logic [31:0] iob_wdata = '0;
  logic [3:0]  iob_wstrb = '0;
  logic [31:0] iob_rdata;
  logic        iob_rvalid;
  logic        iob_ready;
  logic [31:0] gpio_input = '0;
  logic [31:0] gpio_output;
  logic [31:0] gpio_output_enable;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdat;
  logic [5:0]  reg_list [9] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20};

  iob_gpio_irq dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .iob_valid          (iob_valid),
    .iob_addr           (iob_addr),
    .iob_wdata          (iob_wdata),
    .iob_wstrb          (iob_wstrb),
    .iob_rdata          (iob_rdata),
    .iob_rvalid         (iob_rvalid),
    .iob_ready          (iob_ready),
    .gpio_input         (gpio_input),
    .gpio_output        (gpio_output),
    .gpio_output_enable (gpio_output_enable),
    .irq                (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = a;
    iob_wdata = d;
    iob_wstrb = s;
    @(negedge clk);
    chk("wr_ready", {31'd0, iob_ready}, 32'd1);
    iob_valid = 1'b0;
    iob_wstrb = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = a;
    iob_wstrb = '0;
    @(negedge clk);
    chk("rd_rvalid", {31'd0, iob_rvalid}, 32'd1);
    d = iob_rdata;
    iob_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {31'd0, iob_ready}, 32'd0);
    chk("rst_rvalid", {31'd0, iob_rvalid}, 32'd0);
    chk("rst_rdata", iob_rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rd(reg_list[i], rdat);
      chk($sformatf("rst_reg_%02h", reg_list[i]), rdat, 32'd0);
    end
    chk("rst_gpio_out", gpio_output, 32'd0);
    chk("rst_gpio_oe", gpio_output_enable, 32'd0);

    // Scenario 2: output set/clear and byte strobes
    wr(6'h00, 32'h0000_00F0, 4'hF);
    wr(6'h04, 32'h0000_000F, 4'hF);
    wr(6'h08, 32'h0000_0030, 4'hF);
    chk("out_set_clr", gpio_output, 32'h0000_00CF);
    wr(6'h0C, 32'hFFFF_FFFF, 4'b0010);
    chk("oe_wstrb", gpio_output_enable, 32'h0000_FF00);
    rd(6'h0F, rdat);
    chk("oe_rd_low_addr_bits", rdat, 32'h0000_FF00);
    rd(6'h00, rdat);
    chk("out_rd", rdat, 32'h0000_00CF);
    rd(6'h24, rdat);
    chk("unmapped_24", rdat, 32'd0);
    rd(6'h3C, rdat);
    chk("unmapped_3c", rdat, 32'd0);

    // Scenario 3: rising edge with no debounce
    wr(6'h14, 32'h1, 4'hF);
    gpio_input[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rise_irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("rise_irq_after", {31'd0, irq}, 32'd1);
    rd(6'h10, rdat);
    chk("rise_in", rdat, 32'h1);
    rd(6'h1C, rdat);
    chk("rise_status", rdat, 32'h1);
    wr(6'h1C, 32'h1, 4'hF);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    rd(6'h1C, rdat);
    chk("w1c_status", rdat, 32'd0);

    // Scenario 4: debounce rejects a glitch and accepts a held level
    gpio_input[1] = 1'b1;
    repeat (5) @(negedge clk);
    wr(6'h20, 32'd3, 4'hF);
    wr(6'h18, 32'h2, 4'hF);
    repeat (10) @(negedge clk);
    rd(6'h10, rdat);
    chk("dbnc_in_settled", rdat, 32'h3);
    gpio_input[1] = 1'b0;
    repeat (2) @(negedge clk);
    gpio_input[1] = 1'b1;
    repeat (12) @(negedge clk);
    rd(6'h10, rdat);
    chk("glitch_in", rdat, 32'h3);
    rd(6'h1C, rdat);
    chk("glitch_status", rdat, 32'd0);
    gpio_input[1] = 1'b0;
    repeat (12) @(negedge clk);
    rd(6'h10, rdat);
    chk("held_in", rdat, 32'h1);
    rd(6'h1C, rdat);
    chk("held_status", rdat, 32'h2);
    chk("held_irq", {31'd0, irq}, 32'd1);
    wr(6'h1C, 32'h2, 4'hF);
    chk("held_w1c_irq", {31'd0, irq}, 32'd0);

    // Scenario 5: event and W1C on the same bit in the same cycle
    wr(6'h20, 32'd0, 4'hF);
    gpio_input[0] = 1'b0;
    repeat (5) @(negedge clk);
    rd(6'h1C, rdat);
    chk("pre_collide_status", rdat, 32'd0);
    gpio_input[0] = 1'b1;
    repeat (3) @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = 6'h1C;
    iob_wdata = 32'h1;
    iob_wstrb = 4'hF;
    @(negedge clk);
    iob_valid = 1'b0;
    iob_wstrb = '0;
    chk("collide_irq", {31'd0, irq}, 32'd1);
    rd(6'h1C, rdat);
    chk("collide_status", rdat, 32'h1);

    // Scenario 6: reset during activity and mid-access
    wr(6'h14, 32'hFF, 4'hF);
    gpio_input = 32'h0;
    repeat (5) @(negedge clk);
    gpio_input = 32'hFF;
    repeat (5) @(negedge clk);
    rd(6'h1C, rdat);
    chk("pre_rst_status", rdat, 32'hFF);
    wr(6'h20, 32'd5, 4'hF);
    rd(6'h20, rdat);
    chk("pre_rst_debounce", rdat, 32'd5);
    @(negedge clk);
    iob_valid = 1'b1;
    iob_addr  = 6'h1C;
    iob_wstrb = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_gpio_out", gpio_output, 32'd0);
    chk("arst_gpio_oe", gpio_output_enable, 32'd0);
    chk("arst_rdata", iob_rdata, 32'd0);
    gpio_input = 32'h0;
    @(negedge clk);
    chk("arst_no_ready", {31'd0, iob_ready}, 32'd0);
    chk("arst_no_rvalid", {31'd0, iob_rvalid}, 32'd0);
    iob_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rd(reg_list[i], rdat);
      chk($sformatf("post_rst_reg_%02h", reg_list[i]), rdat, 32'd0);
    end
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    chk("post_rst_gpio_out", gpio_output, 32'd0);
    chk("post_rst_gpio_oe", gpio_output_enable, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
